port_b_uart_tx: RTL and testbench

PORT_B_UART_TX -- requirements
Module: port_b_uart_tx

---
 rtl/port_b_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_port_b_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_b_uart_tx.sv
// PORTB write-strobe UART transmitter with a small byte FIFO.
// Optional even parity bit when PORTB_UART_PARITY_EN is defined.
module port_b_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0] DEPTH =
    (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef PORTB_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef PORTB_UART_PARITY_EN
  logic          parity;
`endif
  logic          tick;
  logic          empty;
  logic          pop;
  logic          push;
  logic          tx_next;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  assign tick  = (baud == BAUD_LAST);
  assign busy  = (state != IDLE) || !empty;

  // A pop frees a slot on the same edge, so a
  // write to a full FIFO is still taken then.
  assign pop  = !empty &&
                ((state == IDLE) ||
                 ((state == STOP) && tick));
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
`ifdef PORTB_UART_PARITY_EN
      PARITY:  tx_next = parity;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef PORTB_UART_PARITY_EN
      parity   <= 1'b0;
`endif
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      tx <= tx_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push)
                     - (PW+1)'(pop);
      if (wr_en && !push) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
`ifdef PORTB_UART_PARITY_EN
            parity  <= ^mem[rd_ptr];
`endif
            baud    <= '0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            baud    <= '0;
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef PORTB_UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef PORTB_UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            baud  <= '0;
            state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        STOP: begin
          if (tick) begin
            baud    <= '0;
            bit_cnt <= '0;
            if (pop) begin
              shreg  <= mem[rd_ptr];
`ifdef PORTB_UART_PARITY_EN
              parity <= ^mem[rd_ptr];
`endif
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_b_uart_tx.sv
// Self-checking bench for port_b_uart_tx.
// Uses a bit-level line receiver as reference.
module tb_port_b_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef PORTB_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FLEN = FB * CPB;
  localparam int TMO  = 40 * FLEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  port_b_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .tx(tx),
    .busy(busy),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Line image of one frame, index 0 first.
  function automatic logic [10:0] frame_bits(
    input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef PORTB_UART_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic write(input logic [7:0] b,
                       output int c);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    c = cyc;
  endtask

  // Sample every cycle of one frame after a write.
  task automatic check_wave(input logic [7:0] b);
    logic [10:0] f;
    f = frame_bits(b);
    @(posedge clk);
    #1;
    check("pre_start", tx, 1);
    for (int k = 0; k < FB; k++) begin
      for (int j = 0; j < CPB; j++) begin
        @(posedge clk);
        #1;
        check($sformatf("wave_%0h_b%0d", b, k),
              tx, f[k]);
        if (k == 5 && j == 0)
          check("busy_mid", busy, 1);
      end
    end
    check("busy_end", busy, 0);
    @(posedge clk);
    #1;
    check("idle_tx", tx, 1);
  endtask

  task automatic recv(output logic [7:0] b,
                      output int t0);
    int w;
    w = 0;
    b = 8'h00;
    t0 = -1;
    @(negedge clk);
    while (tx !== 1'b0 && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check("rx_start", tx, 0);
    if (tx !== 1'b0) return;
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_mid", tx, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = tx;
    end
`ifdef PORTB_UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    check("rx_parity", tx, ^b);
`endif
    repeat (CPB) @(negedge clk);
    check("rx_stop", tx, 1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic count_lows(input int n,
                            output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] rb;
    int c0, c1, t0, tp, lows, n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_tx", tx, 1);

    write(8'hA5, c0);
    check_wave(8'hA5);
    write(8'h07, c0);
    check_wave(8'h07);
    wait_idle();

    q = '{8'h11, 8'h22, 8'h33};
    fork
      begin
        write(q[0], c0);
        write(q[1], c1);
        write(q[2], c1);
      end
      begin
        tp = 0;
        for (int i = 0; i < 3; i++) begin
          recv(rb, t0);
          check($sformatf("b2b_byte%0d", i),
                rb, q[i]);
          if (i == 0)
            check("b2b_latency", t0, c0 + 2);
          else
            check($sformatf("b2b_gap%0d", i),
                  t0 - tp, FLEN);
          tp = t0;
        end
      end
    join
    wait_idle();

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++)
        q.push_back(8'($urandom));
      fork
        begin
          for (int i = 0; i < n; i++)
            write(q[i], c1);
        end
        begin
          for (int i = 0; i < n; i++) begin
            recv(rb, t0);
            check($sformatf("rnd%0d_byte%0d", r, i),
                  rb, q[i]);
          end
        end
      join
      wait_idle();
      repeat ($urandom_range(0, 7)) @(posedge clk);
    end

    q = {};
    for (int i = 0; i < 6; i++)
      q.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < 5; i++)
          write(q[i], c1);
        check("pend_full", full, 1);
        repeat (FLEN - 4) @(posedge clk);
        #1;
        check("pend_full_pre", full, 1);
        check("pend_state", busy, 1);
        write(q[5], c1);
        check("pend_ovf", overflow, 0);
        check("pend_full_post", full, 1);
      end
      begin
        tp = 0;
        for (int i = 0; i < 6; i++) begin
          recv(rb, t0);
          check($sformatf("pend_byte%0d", i),
                rb, q[i]);
          if (i > 0)
            check($sformatf("pend_gap%0d", i),
                  t0 - tp, FLEN);
          tp = t0;
        end
      end
    join
    wait_idle();
    check("pend_ovf_end", overflow, 0);

    q = {};
    for (int i = 0; i < 6; i++)
      q.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < 5; i++)
          write(q[i], c1);
        check("ovf_full", full, 1);
        check("ovf_pre", overflow, 0);
        write(q[5], c1);
        check("ovf_set", overflow, 1);
        check("ovf_full2", full, 1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          recv(rb, t0);
          check($sformatf("ovf_byte%0d", i),
                rb, q[i]);
        end
      end
    join
    count_lows(2 * FLEN, lows);
    check("ovf_no_6th", lows, 0);
    check("ovf_busy", busy, 0);
    check("ovf_sticky", overflow, 1);

    rb = 8'($urandom);
    write(rb, c0);
    write(8'($urandom), c1);
    repeat (2 + 4 * CPB) @(posedge clk);
    #2;
    check("abort_bit3", tx, rb[3]);
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_full", full, 0);
    check("abort_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_lows(3 * FLEN, lows);
    check("abort_quiet", lows, 0);
    check("abort_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
